// File: rtl/memory_stage_ctrl.sv
// memory_stage_ctrl: EX/MEM memory access controller with stall, timeout and fault detection (optional MEM_ALIGN_CHECK_EN)
module memory_stage_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr_in,
    input  logic [15:0] WriteData_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        valid_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    input  logic        mem_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] Addr_out,
    output logic [15:0] mem_out_out,
    output logic        stall_out,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
    state_t state;
    logic [7:0] cnt;
    logic [15:0] cap_addr, cap_wdata, data_q;
    logic cap_rd, cap_wr;
    logic idle, busy, req, rd_req, wr_req, misalign, fault, done_ok, rd_done, cnt_hit;
    always_comb begin
        idle = state == IDLE;
        busy = state == BUSY;
        req = valid_in & (MemRead_in | MemWrite_in);
        wr_req = valid_in & MemWrite_in;
        rd_req = valid_in & MemRead_in & ~MemWrite_in;
`ifdef MEM_ALIGN_CHECK_EN
        misalign = req & Addr_in[0];
`else
        misalign = 1'b0;
`endif
        fault = (idle & req & (mem_err | misalign)) | (busy & mem_err);
        done_ok = ((idle & req) | busy) & mem_done & ~fault;
        rd_done = done_ok & (idle ? rd_req : cap_rd);
        cnt_hit = busy & ~mem_done & (cnt + 8'd1 == 8'(TIMEOUT));
        mem_rd = idle ? rd_req & ~misalign : busy & cap_rd;
        mem_wr = idle ? wr_req & ~misalign : busy & cap_wr;
        mem_addr = busy ? cap_addr : Addr_in;
        mem_wdata = busy ? cap_wdata : WriteData_in;
        Addr_out = idle ? Addr_in : cap_addr;
        mem_out_out = rd_done ? mem_data_out : data_q;
        stall_out = (state == ERR) | fault | (((idle & req) | busy) & ~mem_done);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 8'd0;
            err <= 1'b0;
            cap_addr <= 16'd0;
            cap_wdata <= 16'd0;
            cap_rd <= 1'b0;
            cap_wr <= 1'b0;
            data_q <= 16'd0;
        end else begin
            if (rd_done) data_q <= mem_data_out;
            if (idle & req) begin
                cap_addr <= Addr_in;
                cap_wdata <= WriteData_in;
                cap_rd <= rd_req;
                cap_wr <= wr_req;
            end
            if (fault | cnt_hit) begin
                state <= ERR;
                err <= 1'b1;
            end else if (idle & req & ~mem_done) begin
                state <= BUSY;
                cnt <= 8'd0;
            end else if (busy & mem_done) begin
                state <= IDLE;
            end else if (busy) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule
